// File: rtl/_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : _rr_arbiter
// Purpose  : Round-robin arbiter with held, registered one-hot grant + index.
//            Optional hold timeout enabled by defining RR_ARB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module _rr_arbiter #(
    parameter int n        = 2,
    parameter int m        = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [m-1:0] req,
    // `release` is a reserved word, so the owner's end-of-transaction pulse is named release_pulse
    input  logic         release_pulse,
    output logic [m-1:0] grant,
    output logic [n-1:0] grant_idx,
    output logic         busy,
    output logic         timeout
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    localparam logic [n-1:0] c_last = n'(m - 1);
    localparam logic [m-1:0] c_one  = {{(m-1){1'b0}}, 1'b1};

    generate
        if (m < 2 || m > (1 << n) || HOLD_MAX < 1) begin : g_bad_params
            $error("_rr_arbiter: illegal parameter combination");
        end
    endgenerate

    state_t       r_state, w_state_next;
    logic [n-1:0] r_ptr, w_ptr_next;
    logic [n-1:0] r_idx, w_idx_next;
    logic [m-1:0] r_grant, w_grant_next;
    logic [n-1:0] w_base, w_scan, w_winner;
    logic [m-1:0] w_onehot;
    logic         w_found;
    logic         w_rel_event;
    logic         w_force;
    logic         w_new_grant;

    function automatic logic [n-1:0] wrap_inc(input logic [n-1:0] v);
        return (v == c_last) ? '0 : v + n'(1);
    endfunction

    // While owned, the search starts just past the owner so it ends up last
    assign w_base      = (r_state == S_OWNED) ? wrap_inc(r_idx) : r_ptr;
    assign w_rel_event = (r_state == S_OWNED) && (release_pulse || !req[r_idx] || w_force);

    always_comb begin
        w_found  = 1'b0;
        w_winner = w_base;
        w_scan   = w_base;
        for (int i = 0; i < m; i++) begin
            if (!w_found && req[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
            w_scan = wrap_inc(w_scan);
        end
    end

    assign w_onehot = c_one << w_winner;

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_idx_next   = r_idx;
        w_grant_next = r_grant;
        w_new_grant  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_OWNED;
                    w_idx_next   = w_winner;
                    w_grant_next = w_onehot;
                    w_new_grant  = 1'b1;
                end
            end
            S_OWNED: begin
                if (w_rel_event) begin
                    w_ptr_next = wrap_inc(r_idx);
                    if (w_found) begin
                        w_idx_next   = w_winner;
                        w_grant_next = w_onehot;
                        w_new_grant  = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                        w_grant_next = '0;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_idx   <= w_idx_next;
            r_grant <= w_grant_next;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int                  c_hold_w   = $clog2(HOLD_MAX + 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(HOLD_MAX);

    logic [c_hold_w-1:0] r_hold, w_hold_inc;
    logic                r_timeout;

    // Forced release fires on the edge that would complete the HOLD_MAX-th owned cycle
    assign w_hold_inc = (r_hold == c_hold_max) ? r_hold : r_hold + c_hold_w'(1);
    assign w_force    = (r_state == S_OWNED) && (w_hold_inc == c_hold_max);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (w_new_grant || (w_state_next == S_IDLE)) begin
                r_hold <= '0;
            end else begin
                r_hold <= w_hold_inc;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    assign grant     = r_grant;
    assign grant_idx = r_idx;
    assign busy      = (r_state == S_OWNED);

endmodule
`default_nettype wire

// File: tb/tb__rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb__rr_arbiter
// Purpose  : Self-checking bench for _rr_arbiter against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb__rr_arbiter;

    localparam int N        = 2;
    localparam int M        = 4;
    localparam int HOLD_MAX = 16;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit c_to_en = 1'b1;
`else
    localparam bit c_to_en = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [M-1:0] req = '0;
    logic         release_pulse = 1'b0;
    logic [M-1:0] grant;
    logic [N-1:0] grant_idx;
    logic         busy;
    logic         timeout;

    _rr_arbiter #(.n(N), .m(M), .HOLD_MAX(HOLD_MAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .release_pulse (release_pulse),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner -1 means idle
    int mdl_owner = -1;
    int mdl_ptr   = 0;
    int mdl_idx   = 0;
    int mdl_hold  = 0;
    int mdl_to    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick(input logic [M-1:0] r, input int base);
        for (int k = 0; k < M; k++) begin
            if (r[(base + k) % M]) return (base + k) % M;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [M-1:0] r, input logic rl, input logic rs);
        int  w;
        bit  forced;
        if (rs) begin
            mdl_owner = -1; mdl_ptr = 0; mdl_idx = 0; mdl_hold = 0; mdl_to = 0;
        end else if (mdl_owner < 0) begin
            mdl_to = 0;
            w = pick(r, mdl_ptr);
            if (w >= 0) begin
                mdl_owner = w; mdl_idx = w; mdl_hold = 0;
            end
        end else begin
            forced = c_to_en && (mdl_hold + 1 >= HOLD_MAX);
            mdl_to = forced ? 1 : 0;
            if (rl || !r[mdl_owner] || forced) begin
                mdl_ptr   = (mdl_owner + 1) % M;
                w         = pick(r, mdl_ptr);
                mdl_owner = w;
                if (w >= 0) mdl_idx = w;
                mdl_hold  = 0;
            end else if (mdl_hold < HOLD_MAX) begin
                mdl_hold++;
            end
        end
    endtask

    task automatic cycle(input logic [M-1:0] r, input logic rl, input logic rs);
        logic [M-1:0] exp_grant;
        req = r; release_pulse = rl; reset = rs;
        @(posedge clk);
        model_step(r, rl, rs);
        #1;
        exp_grant = (mdl_owner >= 0) ? M'(1 << mdl_owner) : '0;
        check_eq("grant",     32'(grant),     32'(exp_grant));
        check_eq("grant_idx", 32'(grant_idx), 32'(mdl_idx));
        check_eq("busy",      32'(busy),      32'(mdl_owner >= 0));
        check_eq("timeout",   32'(timeout),   32'(mdl_to));
    endtask

    initial begin
        logic [M-1:0] r;
        // Reset held with all requesting, then first grant goes to 0
        cycle(4'b1111, 1'b0, 1'b1);
        cycle(4'b1111, 1'b0, 1'b1);
        cycle(4'b1111, 1'b0, 1'b0);
        check_eq("first_grant", 32'(grant), 32'h1);

        // Single request, then drop it
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0100, 1'b0, 1'b0);
        check_eq("single_idx", 32'(grant_idx), 32'd2);
        cycle(4'b0000, 1'b0, 1'b0);

        // Fairness: release every third cycle
        for (int i = 0; i < 15; i++) cycle(4'b1111, (i % 3) == 2, 1'b0);

        // Skip and pointer wrap
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1001, 1'b0, 1'b0);
        cycle(4'b1001, 1'b1, 1'b0);
        check_eq("skip_to_3", 32'(grant), 32'h8);
        cycle(4'b1001, 1'b1, 1'b0);
        check_eq("wrap_to_0", 32'(grant), 32'h1);

        // Mid-transaction reset with owner 1
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0011, 1'b0, 1'b0);
        cycle(4'b0011, 1'b0, 1'b1);
        cycle(4'b0011, 1'b0, 1'b0);
        check_eq("post_reset", 32'(grant), 32'h1);

        // Long hold with no release
        for (int i = 0; i < 110; i++) cycle(4'b0011, 1'b0, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            r = M'($urandom);
            if (mdl_owner >= 0 && ($urandom % 8) != 0) r[mdl_owner] = 1'b1;
            cycle(r, ($urandom % 4) == 0, ($urandom % 250) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
